// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// valid/ready operand and result handshakes.
module seq_restoring_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         busy
);

    // Handshake rule: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is high only in IDLE, out_valid only in DONE.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;

    logic [N-1:0]  rem_shift;
    logic [N:0]    trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quot_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    // rem never exceeds the dividend bits consumed so far, so the shifted
    // partial remainder always fits in N bits.
    assign rem_shift = {rem_q[N-2:0], quot_q[N-1]};
    assign trial     = {1'b0, rem_shift} - {1'b0, div_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    div_d = divisor;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        quot_d  = dividend;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = CW'(N);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                quot_d = {quot_q[N-2:0], ~trial[N]};
                rem_d  = trial[N] ? rem_shift : trial[N-1:0];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_CALC) || (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (N=4): driver pushes hand-computed
// results into a queue, an independent monitor pops and compares them.
module tb_seq_restoring_divider;

    localparam int N = 4;
    localparam int W = 2 * N + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         busy;

    seq_restoring_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    int           n_acc = 0;
    int           n_abort = 0;
    int           n_taken = 0;
    bit           prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (n_acc > n_taken + n_abort) begin
                check("in_ready_low_while_busy", {31'b0, in_ready}, 32'd0);
                check("busy_high", {31'b0, busy}, 32'd1);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got q=%0d r=%0d dbz=%0d, want no result",
                             quotient, remainder, div_by_zero);
                end else begin
                    if (!prev_valid) check("latency_cycle", cyc, exp_cyc_q[0]);
                    check("result_dbz_q_r", {23'b0, div_by_zero, quotient, remainder}, {23'b0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(exp_cyc_q.pop_front());
                        n_taken++;
                    end
                end
            end
            prev_valid = out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [N-1:0] dd, input logic [N-1:0] ds,
                        input logic [N-1:0] q, input logic [N-1:0] r,
                        input logic dbz, input bit expect_res);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, want 1", guard);
            return;
        end
        dividend = dd;
        divisor  = ds;
        in_valid = 1'b1;
        @(posedge clk);
        if (expect_res) exp_q.push_back({dbz, q, r});
        #1;
        in_valid = 1'b0;
        if (expect_res) exp_cyc_q.push_back(cyc + ((ds == '0) ? 0 : N));
        n_acc++;
        @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, want 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_result", {23'b0, div_by_zero, quotient, remainder}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 13/3 with out_ready high; 7/0
        send(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
        send(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1'b1);
        // back-to-back
        send(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b1);
        send(4'd2, 4'd9, 4'd0, 4'd2, 1'b0, 1'b1);
        wait_drain();

        // back-pressure: result held while out_ready low for 6 cycles
        set_ready(1'b0);
        send(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        set_ready(1'b1);
        @(negedge clk);
        check("idle_after_take_out_valid", {31'b0, out_valid}, 32'd0);
        check("idle_after_take_in_ready", {31'b0, in_ready}, 32'd1);

        // in_valid pulsed during CALC must be ignored
        send(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1'b1);
        dividend = 4'd9;
        divisor  = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_drain();
        repeat (8) @(negedge clk);
        check("idle_after_ignored_pulse", {31'b0, busy}, 32'd0);

        // reset during the second CALC iteration aborts the operation
        send(4'd11, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        n_abort++;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_result", {23'b0, div_by_zero, quotient, remainder}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(4'd10, 4'd3, 4'd3, 4'd1, 1'b0, 1'b1);

        // boundary vectors
        send(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b1);
        send(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b1);
        send(4'd15, 4'd0, 4'd15, 4'd15, 1'b1, 1'b1);
        send(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b1);
        send(4'd3, 4'd7, 4'd0, 4'd3, 1'b0, 1'b1);
        wait_drain();
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
